// File: rtl/rf_wr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// rf_wr_arbiter_pkg
//   Shared defaults and types for the register-file write-port arbiter.
//   Contents:
//     DW_DEFAULT / AW_DEFAULT / MAX_WAIT_DEFAULT : parameter defaults
//     req_idx_t                                  : requester index (EX / MEM)
//     wait_cnt_width()                           : width of a saturating wait counter
// ---------------------------------------------------------------------------
package rf_wr_arbiter_pkg;

  localparam int DW_DEFAULT       = 16;
  localparam int AW_DEFAULT       = 3;
  localparam int MAX_WAIT_DEFAULT = 7;

  // Requester 0 is the execute-stage result, requester 1 the memory-stage load.
  typedef enum logic {
    REQ_EX  = 1'b0,
    REQ_MEM = 1'b1
  } req_idx_t;

  // The counter must be able to hold MAX_WAIT+1 (its saturation value).
  function automatic int wait_cnt_width(input int max_wait);
    return $clog2(max_wait + 2);
  endfunction

endpackage

// File: rtl/rf_wr_arbiter_if.sv
// ---------------------------------------------------------------------------
// rf_wr_arbiter_if
//   Bundles both writeback request channels and the register-file write port.
//   Modports:
//     master : requester/test side (drives reqN_valid/sel/data, sees the rest)
//     slave  : arbiter side (drives reqN_ready, write, writeregsel, writedata,
//              busy_mask, err)
// ---------------------------------------------------------------------------
interface rf_wr_arbiter_if
  import rf_wr_arbiter_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int AW = AW_DEFAULT
);

  logic                 req0_valid;
  logic [AW-1:0]        req0_sel;
  logic [DW-1:0]        req0_data;
  logic                 req0_ready;

  logic                 req1_valid;
  logic [AW-1:0]        req1_sel;
  logic [DW-1:0]        req1_data;
  logic                 req1_ready;

  logic                 write;
  logic [AW-1:0]        writeregsel;
  logic [DW-1:0]        writedata;
  logic [(1<<AW)-1:0]   busy_mask;
  logic                 err;

  modport master (
    output req0_valid, req0_sel, req0_data,
    input  req0_ready,
    output req1_valid, req1_sel, req1_data,
    input  req1_ready,
    input  write, writeregsel, writedata, busy_mask, err
  );

  modport slave (
    input  req0_valid, req0_sel, req0_data,
    output req0_ready,
    input  req1_valid, req1_sel, req1_data,
    output req1_ready,
    output write, writeregsel, writedata, busy_mask, err
  );

endinterface

// File: rtl/rf_wr_req_mon.sv
// ---------------------------------------------------------------------------
// rf_wr_req_mon
//   Per-requester watchdog: counts consecutive stalled cycles and checks that a
//   stalled request keeps valid/sel/data stable until it is accepted.
//   Ports:
//     clk, rst   : clock, asynchronous active-low reset
//     valid      : requester valid
//     ready      : grant returned to the requester
//     sel, data  : request payload
//     err_event  : 1 in a cycle whose closing edge must set the sticky error
// ---------------------------------------------------------------------------
module rf_wr_req_mon
  import rf_wr_arbiter_pkg::*;
#(
  parameter int DW       = DW_DEFAULT,
  parameter int AW       = AW_DEFAULT,
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid,
  input  logic          ready,
  input  logic [AW-1:0] sel,
  input  logic [DW-1:0] data,
  output logic          err_event
);

  localparam int            CW   = wait_cnt_width(MAX_WAIT);
  localparam logic [CW-1:0] LAST = CW'(MAX_WAIT);
  localparam logic [CW-1:0] SAT  = CW'(MAX_WAIT + 1);

  logic          stall;
  logic          stalled_q;
  logic [AW-1:0] sel_q;
  logic [DW-1:0] data_q;
  logic [CW-1:0] wait_cnt;
  logic          proto_err;
  logic          starve_err;

  assign stall = valid & ~ready;

  // Remember last cycle's payload and stall state; the wait counter restarts
  // whenever the request is accepted or withdrawn.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stalled_q <= 1'b0;
      sel_q     <= '0;
      data_q    <= '0;
      wait_cnt  <= '0;
    end else begin
      stalled_q <= stall;
      sel_q     <= sel;
      data_q    <= data;
      if (!stall) begin
        wait_cnt <= '0;
      end else if (wait_cnt != SAT) begin
        wait_cnt <= wait_cnt + CW'(1);
      end
    end
  end

  // A stalled request must still be there, unchanged, in the following cycle.
  // Starvation is flagged on the edge that takes the counter to MAX_WAIT+1.
  always_comb begin
    proto_err  = stalled_q & (~valid | (sel != sel_q) | (data != data_q));
    starve_err = stall & (wait_cnt >= LAST);
    err_event  = proto_err | starve_err;
  end

endmodule

// File: rtl/rf_wr_arbiter.sv
// ---------------------------------------------------------------------------
// rf_wr_arbiter
//   Shares the single register-file write port between the execute-stage
//   result (req0) and the memory-stage load result (req1). The grant is
//   combinational; the winning write is registered (one cycle latency).
//   Ports:
//     clk  : clock, rising edge
//     rst  : asynchronous active-low reset
//     bus  : rf_wr_arbiter_if.slave (request channels, write port,
//            busy_mask, sticky err)
//   Parameters: DW, AW, MAX_WAIT, FIXED_PRI (0 = round-robin, 1 = req1 wins)
// ---------------------------------------------------------------------------
module rf_wr_arbiter
  import rf_wr_arbiter_pkg::*;
#(
  parameter int DW        = DW_DEFAULT,
  parameter int AW        = AW_DEFAULT,
  parameter int MAX_WAIT  = MAX_WAIT_DEFAULT,
  parameter int FIXED_PRI = 0
) (
  input logic            clk,
  input logic            rst,
  rf_wr_arbiter_if.slave bus
);

  localparam bit RR_MODE = (FIXED_PRI == 0);

  req_idx_t           rr_ptr;
  logic               grant0;
  logic               grant1;
  logic               both_valid;
  logic               write_q;
  logic [AW-1:0]      sel_q;
  logic [DW-1:0]      data_q;
  logic               err_q;
  logic               err_event0;
  logic               err_event1;
  logic [(1<<AW)-1:0] busy;

  // req0 wins when alone, or under contention when round-robin favours it;
  // otherwise req1 takes any cycle in which it is valid.
  always_comb begin
    both_valid = bus.req0_valid & bus.req1_valid;
    grant0     = bus.req0_valid &
                 (~bus.req1_valid | (RR_MODE && (rr_ptr == REQ_EX)));
    grant1     = bus.req1_valid & ~grant0;
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;

  // After a contended cycle the pointer favours whoever lost it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= REQ_EX;
    end else if (both_valid) begin
      rr_ptr <= grant0 ? REQ_MEM : REQ_EX;
    end
  end

  // Output stage: the register file never stalls, so every grant becomes a
  // write on the next edge. Address/data hold when nothing is granted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      write_q <= 1'b0;
      sel_q   <= '0;
      data_q  <= '0;
    end else begin
      write_q <= grant0 | grant1;
      if (grant1) begin
        sel_q  <= bus.req1_sel;
        data_q <= bus.req1_data;
      end else if (grant0) begin
        sel_q  <= bus.req0_sel;
        data_q <= bus.req0_data;
      end
    end
  end

  assign bus.write       = write_q;
  assign bus.writeregsel = sel_q;
  assign bus.writedata   = data_q;

  // Registers with a write either stalled at the input or sitting in the
  // output stage.
  always_comb begin
    busy = '0;
    if (bus.req0_valid && !grant0) begin
      busy[bus.req0_sel] = 1'b1;
    end
    if (bus.req1_valid && !grant1) begin
      busy[bus.req1_sel] = 1'b1;
    end
    if (write_q) begin
      busy[sel_q] = 1'b1;
    end
  end

  assign bus.busy_mask = busy;

  rf_wr_req_mon #(
    .DW       (DW),
    .AW       (AW),
    .MAX_WAIT (MAX_WAIT)
  ) u_mon_ex (
    .clk       (clk),
    .rst       (rst),
    .valid     (bus.req0_valid),
    .ready     (grant0),
    .sel       (bus.req0_sel),
    .data      (bus.req0_data),
    .err_event (err_event0)
  );

  rf_wr_req_mon #(
    .DW       (DW),
    .AW       (AW),
    .MAX_WAIT (MAX_WAIT)
  ) u_mon_mem (
    .clk       (clk),
    .rst       (rst),
    .valid     (bus.req1_valid),
    .ready     (grant1),
    .sel       (bus.req1_sel),
    .data      (bus.req1_data),
    .err_event (err_event1)
  );

  // Sticky error; only reset clears it, arbitration is unaffected.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_q | err_event0 | err_event1;
    end
  end

  assign bus.err = err_q;

endmodule
